monobit_bitgen: RTL
===================

// Module: monobit_bitgen
// PURPOSE
// - Stimulus/transmit end of the monobit epsilon interface: generates serial test blocks of BLOCK_LEN bits, one bit per clock.
// - Drives the monobit tester's epsilon input, then waits for its valid/is_random verdict.
// - Tallies the verdicts into pass/fail counters.
// - On-chip self-test source for the monobit tester; selectable bit patterns give known-random and known-biased streams.
// PARAMETERS
// - BLOCK_LEN  128      bits per test block; power of 2, >= 8
// - LFSR_W     16       Fibonacci LFSR width
// - LFSR_TAPS  16'hB400 feedback tap mask, x^16+x^14+x^13+x^11+1
// - CNT_W      8        pass/fail/block counter width
// - TIMEOUT    255      max cycles in WAIT_RES before a forced fail
// PORTS
// - clk           in   1      clock, rising edge
// - rst_n         in   1      one clock domain; asynchronous, active-low reset
// - start         in   1      1-cycle pulse; honoured only in IDLE or DONE
// - abort         in   1      synchronous return to IDLE; counters are held
// - mode          in   2      0 = LFSR, 1 = all-ones, 2 = alternating 0101.., 3 = repeat seed[7:0] LSB-first
// - seed          in   8      LFSR seed / repeat pattern; latched at start
// - n_blocks      in   CNT_W  number of blocks to send; 0 = continuous; latched at start
// - epsilon       out  1      serial test bit, to the tester's epsilon input
// - epsilon_vld   out  1      high while epsilon carries a block bit
// - valid_in      in   1      tester verdict strobe
// - is_random_in  in   1      tester verdict; sampled when valid_in = 1
// - busy          out  1      state is RUN or WAIT_RES
// - done          out  1      high in DONE
// - timeout_err   out  1      sticky; cleared by start
// - pass_cnt      out  CNT_W  saturating count of is_random = 1 verdicts
// - fail_cnt      out  CNT_W  saturating count of fails and timeouts
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; lfsr 0; bit_idx, blk_cnt and tmo counter 0.
// - FSM: IDLE -> RUN -> WAIT_RES -> RUN or DONE. DONE -> RUN on start.
//   - IDLE/DONE + start: latch mode, seed, n_blocks; lfsr <= {seed, ~seed} (never zero).
//     Clear pass_cnt, fail_cnt, blk_cnt, bit_idx and timeout_err. Go to RUN.
//   - The first bit appears the cycle after start.
//   - RUN: epsilon_vld = 1.
//     - epsilon = lfsr[0] | 1 | bit_idx[0] | seed_q[bit_idx[2:0]], per mode 0/1/2/3.
//     - epsilon and epsilon_vld are decoded from registered state only; no input feeds them combinationally.
//     - Each RUN cycle: bit_idx++. In mode 0 the LFSR shifts right: lfsr <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]}.
//     - On bit_idx == BLOCK_LEN-1: bit_idx <= 0, tmo <= 0, go to WAIT_RES.
//     - LFSR state continues across blocks; it is not reseeded.
//   - WAIT_RES: epsilon_vld = 0, epsilon = 0. tmo counts up each cycle.
//     - valid_in = 1: pass_cnt++ if is_random_in, else fail_cnt++. blk_cnt++.
//     - tmo reaches TIMEOUT with no valid_in: fail_cnt++, timeout_err <= 1, blk_cnt++.
//     - After either event: if n_blocks != 0 and blk_cnt+1 == n_blocks go to DONE, else go to RUN.
//     - valid_in in the same cycle that the timeout expires: the valid verdict wins; no timeout is recorded.
//   - valid_in outside WAIT_RES: ignored.
// - Counters saturate at 2^CNT_W-1.
//   - blk_cnt wraps in continuous mode (n_blocks = 0); it is never compared there.
// - abort in any state: go to IDLE next cycle; epsilon_vld drops; counters and timeout_err are held.
//   - abort together with start: abort wins.
// - start while busy: ignored.
// - Reset mid-operation: immediate asynchronous return to all reset values.
// STRUCTURE
// - Shared package monobit_pkg:
//   - state enum {IDLE, RUN, WAIT_RES, DONE}
//   - mode constants MODE_LFSR, MODE_ONES, MODE_ALT, MODE_PAT
//   - default BLOCK_LEN, shared with the tester
// - One sub-module: monobit_lfsr. Inputs: load, seed, shift_en. Outputs: state, bit.
// - FSM, counters and output mux stay in this module.
// TESTING
// - mode 1, n_blocks = 1; bench returns valid = 1, is_random = 0 three cycles after the last bit.
//   -> 128 ones with epsilon_vld high for exactly 128 cycles; fail_cnt = 1; done = 1.
// - mode 2, n_blocks = 3; bench returns is_random = 1 each block.
//   -> each block has 64 ones and 64 zeros, first bit 0; pass_cnt = 3.
// - mode 0, seed = 8'hA5; compare against a reference LFSR model.
//   -> first 16 bits are LSB-first of 16'hA55A; the stream matches the model for 2 blocks.
// - mode 3, seed = 8'h0F, n_blocks = 2; bench never asserts valid.
//   -> WAIT_RES lasts TIMEOUT cycles; fail_cnt = 2; timeout_err = 1; done = 1.
// - n_blocks = 0; abort at bit 40 of block 2.
//   -> epsilon_vld low next cycle, state IDLE, pass_cnt holds 1.
//   -> a following start clears all counters.
// - rst_n low mid-block, then valid_in pulse and start pulse while busy.
//   -> all outputs 0 at once; valid_in is ignored in RUN; start while busy has no effect.

Source files
------------

// File: rtl/monobit_pkg.sv
// Shared definitions for the monobit epsilon interface (generator and tester).
package monobit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned SEED_W = 8;

  localparam logic [MODE_W-1:0] MODE_LFSR = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ONES = 2'd1;
  localparam logic [MODE_W-1:0] MODE_ALT  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_PAT  = 2'd3;

  // Block length agreed between generator and tester
  localparam int unsigned DEF_BLOCK_LEN = 128;

endpackage

// File: rtl/monobit_lfsr.sv
// Fibonacci LFSR, right-shifting; the serial bit is the LSB.
module monobit_lfsr #(
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              shift_en,
  output logic [LFSR_W-1:0] state,
  output logic              cur_bit
);

  // Load has priority over shift; feedback enters at the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (shift_en) begin
      state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
    end
  end

  assign cur_bit = state[0];

endmodule

// File: rtl/monobit_bitgen.sv
// Monobit self-test source: serial block generator plus verdict tally.
module monobit_bitgen
  import monobit_pkg::*;
#(
  parameter int unsigned       BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400),
  parameter int unsigned       CNT_W     = 8,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [MODE_W-1:0] mode,
  input  logic [SEED_W-1:0] seed,
  input  logic [CNT_W-1:0]  n_blocks,
  output logic              epsilon,
  output logic              epsilon_vld,
  input  logic              valid_in,
  input  logic              is_random_in,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);

  localparam int unsigned IDX_W = $clog2(BLOCK_LEN);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [MODE_W-1:0]   mode_q;
  logic [SEED_W-1:0]   seed_q;
  logic [CNT_W-1:0]    n_blocks_q;
  logic [CNT_W-1:0]    blk_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic [TMO_W-1:0]    tmo;

  logic                start_ok;
  logic                lfsr_shift;
  logic [LFSR_W-1:0]   lfsr_state;
  logic                lfsr_bit;
  logic                lfsr_unused;
  logic                last_bit;
  logic                expired;
  logic                last_blk;

  // Control decodes from registered state and the current inputs
  assign start_ok   = start && !abort && ((state == IDLE) || (state == DONE));
  assign lfsr_shift = !abort && (state == RUN) && (mode_q == MODE_LFSR);
  assign last_bit   = (bit_idx == IDX_W'(BLOCK_LEN - 1));
  assign expired    = !valid_in && (tmo == TMO_W'(TIMEOUT - 1));
  assign last_blk   = (n_blocks_q != '0) && ((blk_cnt + CNT_W'(1)) == n_blocks_q);

  // Seed is widened with its complement so the register can never load all zeros
  monobit_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .seed     (LFSR_W'({seed, ~seed})),
    .shift_en (lfsr_shift),
    .state    (lfsr_state),
    .cur_bit  (lfsr_bit)
  );

  // Only the serial bit is consumed here; the full state is for observation
  assign lfsr_unused = ^lfsr_state;

  // Sequencer: block bit counting, verdict collection, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= '0;
      seed_q      <= '0;
      n_blocks_q  <= '0;
      blk_cnt     <= '0;
      bit_idx     <= '0;
      tmo         <= '0;
      timeout_err <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q      <= mode;
            seed_q      <= seed;
            n_blocks_q  <= n_blocks;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            blk_cnt     <= '0;
            bit_idx     <= '0;
            timeout_err <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (last_bit) begin
            bit_idx <= '0;
            tmo     <= '0;
            state   <= WAIT_RES;
          end else begin
            bit_idx <= bit_idx + IDX_W'(1);
          end
        end
        WAIT_RES: begin
          tmo <= tmo + TMO_W'(1);
          if (valid_in) begin
            if (is_random_in) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            end
          end else if (expired) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            timeout_err <= 1'b1;
          end
          if (valid_in || expired) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
            state   <= last_blk ? DONE : RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial output mux, decoded from registered state only
  always_comb begin
    epsilon_vld = (state == RUN);
    epsilon     = 1'b0;
    if (state == RUN) begin
      case (mode_q)
        MODE_LFSR: epsilon = lfsr_bit;
        MODE_ONES: epsilon = 1'b1;
        MODE_ALT:  epsilon = bit_idx[0];
        default:   epsilon = seed_q[bit_idx[2:0]];
      endcase
    end
  end

  assign busy = (state == RUN) || (state == WAIT_RES);
  assign done = (state == DONE);

endmodule
